fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
- Upstream configuration stage for the FIR filter datapath.
- Accepts coefficient writes one tap at a time over a valid/ready interface into a shadow bank.
- On an explicit commit, swaps the whole shadow bank into the active bank atomically; the filter's flat coefficient bus never sees a half-updated set.
- Drives the FIR coefficient input directly.

Parameters:
- NB_COEFFS, 8, width of one signed coefficient.
- N_COEFFS, 8, number of taps (need not be a power of two).
- NB_ADDR, $clog2(N_COEFFS), tap address width (minimum 1).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_valid  in  1  coefficient write request.
- i_wr_addr  in  NB_ADDR  tap index; 0 = tap applied to newest sample.
- i_wr_data  in  NB_COEFFS  signed coefficient value.
- o_wr_ready  out  1  write accepted when i_wr_valid and o_wr_ready are both high at a rising edge.
- i_commit  in  1  request to copy shadow bank to active bank.
- o_coeffs  out  NB_COEFFS*N_COEFFS  active bank; tap k at bits [(k+1)*NB_COEFFS-1 -: NB_COEFFS]; registered.
- o_updated  out  1  one-cycle pulse when the new active set is first visible on o_coeffs.
- o_err  out  1  one-cycle pulse on a rejected commit or a dropped write.

Behaviour:
- One clock, i_clock; reset i_rst_n is asynchronous and active-low. Assertion immediately clears:
  - active bank, shadow bank and written-mask to 0;
  - state to IDLE;
  - o_updated and o_err to 0.
- After reset release: o_coeffs = 0, o_wr_ready = 1.
- State machine:
  - IDLE: o_wr_ready = 1; writes and commits accepted.
  - COMMIT: lasts exactly one cycle; o_wr_ready = 0; at the end of the cycle, active <= shadow and the written-mask is cleared; always returns to IDLE.
- Write accepted in IDLE:
  - shadow[addr] <= data; mask[addr] <= 1 at the same edge.
  - Rewriting a tap before commit overwrites it; last write wins.
- Write with i_wr_addr >= N_COEFFS: handshake completes, data is dropped, mask unchanged, o_err pulses the next cycle.
- Writes while in COMMIT: not accepted (ready low). The source must hold valid, addr and data; the write is accepted in the following IDLE cycle.
- Commit evaluated in IDLE at edge T uses the mask including any write accepted at the same edge T.
  - Mask complete (all N_COEFFS bits set): go to COMMIT at T+1. o_coeffs shows the new set from T+2; o_updated is high for the cycle starting at T+2.
  - Mask incomplete: commit ignored, stay IDLE, shadow and mask retained, o_err high for the cycle after T.
- i_commit high while in COMMIT: ignored silently.
- i_commit held high continuously: each IDLE cycle evaluates it. After a successful commit the mask is clear, so the next evaluation errors. Sources pulse i_commit for one cycle.
- o_coeffs changes only on a successful commit or on reset; never mid-load.
- Coefficients are stored verbatim; no arithmetic, no sign extension.
- Reset mid-load or mid-commit: everything is cleared; no partial bank survives.

Test Plan:
- Reset: assert i_rst_n low mid-cycle -> o_coeffs = 0, o_updated = 0, o_err = 0 asynchronously; o_wr_ready = 1 after release.
- Full load: write taps 0..7 = 0x01..0x08, then pulse commit at edge T -> o_coeffs = 0x0807060504030201 from T+2; o_updated high exactly one cycle; o_wr_ready low at T+1.
- Incomplete commit: write taps 0..6 only, commit -> o_err one-cycle pulse, o_coeffs unchanged. Then write tap 7 = 0x80 and commit -> o_coeffs top byte = 0x80.
- Same-cycle write+commit: taps 0..6 written, then tap 7 written in the same cycle as commit -> commit succeeds, new set includes tap 7.
- Write held across COMMIT: assert a write to tap 3 = 0xFF during the COMMIT cycle -> not accepted that cycle, accepted next cycle; active tap 3 unchanged; mask shows only tap 3 set.
- N_COEFFS = 6 and async reset:
  - write addr 6 -> o_err pulse, no mask change;
  - reset asserted after 3 writes -> subsequent commit after only those 3 taps are rewritten errors.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Configuration stage in front of the FIR datapath. Coefficients arrive one
//   tap at a time over a valid/ready interface and land in a shadow bank. A
//   commit copies the whole shadow bank into the active bank in one edge, so
//   the filter never sees a partially updated set.
//
// Ports
//   i_clock     system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_wr_valid  coefficient write request
//   i_wr_addr   tap index (0 = tap applied to newest sample)
//   i_wr_data   signed coefficient, stored verbatim
//   o_wr_ready  write accepted when valid and ready are high at a rising edge
//   i_commit    request to copy shadow bank into active bank
//   o_coeffs    active bank, tap k at [(k+1)*NB_COEFFS-1 -: NB_COEFFS]
//   o_updated   one-cycle pulse when a new set first appears on o_coeffs
//   o_err       one-cycle pulse on a rejected commit or dropped write
module fir_coeff_loader #(
  parameter int NB_COEFFS = 8,
  parameter int N_COEFFS  = 8,
  parameter int NB_ADDR   = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1
) (
  input  logic                          i_clock,
  input  logic                          i_rst_n,
  input  logic                          i_wr_valid,
  input  logic [NB_ADDR-1:0]            i_wr_addr,
  input  logic [NB_COEFFS-1:0]          i_wr_data,
  output logic                          o_wr_ready,
  input  logic                          i_commit,
  output logic [NB_COEFFS*N_COEFFS-1:0] o_coeffs,
  output logic                          o_updated,
  output logic                          o_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  localparam logic [NB_ADDR:0] ADDR_LIMIT = (NB_ADDR+1)'(N_COEFFS);

  state_t state;
  state_t state_next;

  logic [NB_COEFFS-1:0] shadow [N_COEFFS];
  logic [NB_COEFFS-1:0] active [N_COEFFS];
  logic [N_COEFFS-1:0]  mask;
  logic [N_COEFFS-1:0]  wr_onehot;
  logic [N_COEFFS-1:0]  mask_merged;

  logic wr_fire;
  logic addr_in_range;
  logic commit_req;
  logic commit_ok;
  logic commit_bad;
  logic load_active;

  // State register
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: COMMIT always lasts exactly one cycle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (commit_ok) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode from state
  always_comb begin
    o_wr_ready  = (state == IDLE);
    load_active = (state == COMMIT);
    commit_req  = (state == IDLE) && i_commit;
  end

  assign wr_fire       = i_wr_valid && o_wr_ready;
  assign addr_in_range = ({1'b0, i_wr_addr} < ADDR_LIMIT);

  always_comb begin
    wr_onehot = '0;
    for (int unsigned k = 0; k < N_COEFFS; k++) begin
      if (wr_fire && addr_in_range && (i_wr_addr == NB_ADDR'(k))) begin
        wr_onehot[k] = 1'b1;
      end
    end
  end

  // Commit completeness includes a write accepted at the same edge
  assign mask_merged = mask | wr_onehot;
  assign commit_ok   = commit_req && (&mask_merged);
  assign commit_bad  = commit_req && !(&mask_merged);

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow    <= '{default: '0};
      active    <= '{default: '0};
      mask      <= '0;
      o_updated <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_COEFFS; k++) begin
        if (wr_onehot[k]) begin
          shadow[k] <= i_wr_data;
        end
      end
      // No write can be accepted during COMMIT, so clearing the mask there
      // cannot lose a freshly written tap.
      if (load_active) begin
        active <= shadow;
        mask   <= '0;
      end else begin
        mask   <= mask_merged;
      end
      o_updated <= load_active;
      o_err     <= commit_bad || (wr_fire && !addr_in_range);
    end
  end

  always_comb begin
    o_coeffs = '0;
    for (int unsigned k = 0; k < N_COEFFS; k++) begin
      o_coeffs[k*NB_COEFFS +: NB_COEFFS] = active[k];
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: an 8-tap and a 6-tap instance. Stimulus pushes
// the expected o_updated/o_err events into per-instance queues; monitors pop
// and compare whenever a pulse appears and track the expected active bank.
module tb_fir_coeff_loader;

  typedef struct {
    bit          is_err;
    logic [63:0] co;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        v8, c8, rdy8, up8, err8;
  logic [2:0]  a8;
  logic [7:0]  d8;
  logic [63:0] co8;

  logic        v6, c6, rdy6, up6, err6;
  logic [2:0]  a6;
  logic [7:0]  d6;
  logic [47:0] co6;

  exp_t        q8[$];
  exp_t        q6[$];
  logic [63:0] act8_m, act6_m;
  logic [63:0] exp8, exp6;

  int checks = 0;
  int errors = 0;

  fir_coeff_loader #(.NB_COEFFS(8), .N_COEFFS(8)) u_dut8 (
    .i_clock(clk), .i_rst_n(rst_n),
    .i_wr_valid(v8), .i_wr_addr(a8), .i_wr_data(d8), .o_wr_ready(rdy8),
    .i_commit(c8), .o_coeffs(co8), .o_updated(up8), .o_err(err8)
  );

  fir_coeff_loader #(.NB_COEFFS(8), .N_COEFFS(6)) u_dut6 (
    .i_clock(clk), .i_rst_n(rst_n),
    .i_wr_valid(v6), .i_wr_addr(a6), .i_wr_data(d6), .o_wr_ready(rdy6),
    .i_commit(c6), .o_coeffs(co6), .o_updated(up6), .o_err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Monitors
  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst_n) begin
      exp8 = '0;
    end else begin
      if (up8 || err8) begin
        if (q8.size() == 0) begin
          chk("dut8_unexpected_pulse", {62'b0, up8, err8}, 64'h0);
        end else begin
          e = q8.pop_front();
          chk("dut8_pulse_kind", {62'b0, up8, err8}, e.is_err ? 64'h1 : 64'h2);
          exp8 = e.co;
        end
      end
      chk("dut8_coeffs", co8, exp8);
    end
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (!rst_n) begin
      exp6 = '0;
    end else begin
      if (up6 || err6) begin
        if (q6.size() == 0) begin
          chk("dut6_unexpected_pulse", {62'b0, up6, err6}, 64'h0);
        end else begin
          e = q6.pop_front();
          chk("dut6_pulse_kind", {62'b0, up6, err6}, e.is_err ? 64'h1 : 64'h2);
          exp6 = e.co;
        end
      end
      chk("dut6_coeffs", {16'h0, co6}, exp6);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit u6, input bit is_err, input logic [63:0] co);
    exp_t e;
    e.is_err = is_err;
    e.co     = co;
    if (u6) q6.push_back(e);
    else    q8.push_back(e);
  endtask

  task automatic wr(input bit u6, input logic [2:0] a, input logic [7:0] d);
    int unsigned n;
    n = 0;
    if (u6) begin v6 = 1'b1; a6 = a; d6 = d; end
    else    begin v8 = 1'b1; a8 = a; d8 = d; end
    while (!(u6 ? rdy6 : rdy8) && n < 20) begin
      step();
      n++;
    end
    chk("wr_ready_timeout", 64'(n >= 20), 64'h0);
    step();
    if (u6) v6 = 1'b0;
    else    v8 = 1'b0;
  endtask

  // Successful commits hold i_commit through the COMMIT cycle, where it
  // must be ignored.
  task automatic commit(input bit u6, input bit ok, input logic [63:0] nv);
    if (u6) c6 = 1'b1;
    else    c8 = 1'b1;
    step();
    if (ok) begin
      chk(u6 ? "dut6_ready_in_commit" : "dut8_ready_in_commit",
          64'(u6 ? rdy6 : rdy8), 64'h0);
      push(u6, 1'b0, nv);
      if (u6) act6_m = nv;
      else    act8_m = nv;
      step();
    end else begin
      push(u6, 1'b1, u6 ? act6_m : act8_m);
    end
    if (u6) c6 = 1'b0;
    else    c8 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    v8 = 0; c8 = 0; a8 = '0; d8 = '0;
    v6 = 0; c6 = 0; a6 = '0; d6 = '0;
    act8_m = '0; act6_m = '0;

    // Reset state
    repeat (3) step();
    chk("rst_co8", co8, 64'h0);
    chk("rst_up8", 64'(up8), 64'h0);
    chk("rst_err8", 64'(err8), 64'h0);
    chk("rst_co6", {16'h0, co6}, 64'h0);
    rst_n = 1'b1;
    step();
    chk("rst_rdy8", 64'(rdy8), 64'h1);
    chk("rst_rdy6", 64'(rdy6), 64'h1);

    // Full load
    for (int k = 0; k < 8; k++) wr(0, 3'(k), 8'(k + 1));
    commit(0, 1, 64'h0807060504030201);

    // Incomplete commit, then finish the bank
    for (int k = 0; k < 7; k++) wr(0, 3'(k), 8'(8'h11 + k));
    commit(0, 0, 64'h0);
    wr(0, 3'd7, 8'h80);
    commit(0, 1, 64'h8017161514131211);

    // Last tap written in the same cycle as commit
    for (int k = 0; k < 7; k++) wr(0, 3'(k), 8'(8'h21 + k));
    v8 = 1'b1; a8 = 3'd7; d8 = 8'hA5; c8 = 1'b1;
    step();
    v8 = 1'b0; c8 = 1'b0;
    chk("same_cycle_ready", 64'(rdy8), 64'h0);
    push(0, 1'b0, 64'hA527262524232221);
    act8_m = 64'hA527262524232221;
    step();

    // Write held across the COMMIT cycle
    for (int k = 0; k < 8; k++) wr(0, 3'(k), 8'(8'h31 + k));
    c8 = 1'b1;
    step();
    c8 = 1'b0;
    chk("held_ready_commit", 64'(rdy8), 64'h0);
    push(0, 1'b0, 64'h3837363534333231);
    act8_m = 64'h3837363534333231;
    v8 = 1'b1; a8 = 3'd3; d8 = 8'hFF;
    step();
    chk("held_ready_idle", 64'(rdy8), 64'h1);
    step();
    v8 = 1'b0;
    commit(0, 0, 64'h0);
    for (int k = 0; k < 8; k++) if (k != 3) wr(0, 3'(k), 8'(8'h40 + k));
    commit(0, 1, 64'h47464544FF424140);

    // Six-tap instance: out-of-range writes are dropped with an error
    for (int k = 0; k < 5; k++) wr(1, 3'(k), 8'(k + 1));
    wr(1, 3'd6, 8'h99);
    push(1, 1'b1, act6_m);
    commit(1, 0, 64'h0);
    wr(1, 3'd7, 8'h77);
    push(1, 1'b1, act6_m);
    wr(1, 3'd5, 8'h06);
    commit(1, 1, 64'h0000060504030201);

    // Reset mid-load
    repeat (3) step();
    for (int k = 0; k < 3; k++) wr(1, 3'(k), 8'(8'h51 + k));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_co6", {16'h0, co6}, 64'h0);
    chk("async_rst_co8", co8, 64'h0);
    chk("async_rst_up6", 64'(up6), 64'h0);
    chk("async_rst_err6", 64'(err6), 64'h0);
    act8_m = '0; act6_m = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy6", 64'(rdy6), 64'h1);
    for (int k = 0; k < 3; k++) wr(1, 3'(k), 8'(8'h51 + k));
    commit(1, 0, 64'h0);
    commit(0, 0, 64'h0);

    repeat (4) step();
    chk("q8_drained", 64'(q8.size()), 64'h0);
    chk("q6_drained", 64'(q6.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
